// File: rtl/fasttwosum_reduce_seq.sv
// Serial frame reducer: folds a stream of compensated (sum, error) partials into one
// pair by scheduling acc-plus-element operand sets onto an external fixed-latency merge unit.
module fasttwosum_reduce_seq #(
  parameter int EXP_WIDTH_I  = 5,
  parameter int MANT_WIDTH_I = 2,
  parameter int MERGE_LAT    = 3,
  parameter int CNT_WIDTH    = 16,
  localparam int BIT_WIDTH_I = 1 + EXP_WIDTH_I + MANT_WIDTH_I
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [BIT_WIDTH_I-1:0] in_sum_i,
  input  logic [BIT_WIDTH_I-1:0] in_error_i,
  input  logic                   in_last_i,
  output logic [BIT_WIDTH_I-1:0] mrg_sum_a_o,
  output logic [BIT_WIDTH_I-1:0] mrg_error_a_o,
  output logic [BIT_WIDTH_I-1:0] mrg_sum_b_o,
  output logic [BIT_WIDTH_I-1:0] mrg_error_b_o,
  input  logic [BIT_WIDTH_I-1:0] mrg_sum_i,
  input  logic [BIT_WIDTH_I-1:0] mrg_error_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [BIT_WIDTH_I-1:0] out_sum_o,
  output logic [BIT_WIDTH_I-1:0] out_error_o,
  output logic [CNT_WIDTH-1:0]   out_count_o
);

  localparam int WCNT_W = $clog2(MERGE_LAT + 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ACC   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [BIT_WIDTH_I-1:0] acc_sum_r;
  logic [BIT_WIDTH_I-1:0] acc_err_r;
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic [CNT_WIDTH-1:0]   cnt_inc_s;
  logic [WCNT_W-1:0]      wcnt_r;
  logic                   last_pend_r;
  logic [BIT_WIDTH_I-1:0] mrg_sum_a_r;
  logic [BIT_WIDTH_I-1:0] mrg_error_a_r;
  logic [BIT_WIDTH_I-1:0] mrg_sum_b_r;
  logic [BIT_WIDTH_I-1:0] mrg_error_b_r;
  logic                   in_hs_s;

  assign in_ready_o    = (state_r == ST_EMPTY) || (state_r == ST_ACC);
  assign out_valid_o   = (state_r == ST_DONE);
  assign out_sum_o     = acc_sum_r;
  assign out_error_o   = acc_err_r;
  assign out_count_o   = cnt_r;
  assign mrg_sum_a_o   = mrg_sum_a_r;
  assign mrg_error_a_o = mrg_error_a_r;
  assign mrg_sum_b_o   = mrg_sum_b_r;
  assign mrg_error_b_o = mrg_error_b_r;

  // Next-state decode, handshake qualification and saturating count increment
  always_comb begin
    state_s = state_r;
    in_hs_s = in_valid_i && in_ready_o;
    if (cnt_r == {CNT_WIDTH{1'b1}}) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
    case (state_r)
      ST_EMPTY: begin
        if (in_hs_s) begin
          state_s = in_last_i ? ST_DONE : ST_ACC;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_ACC: begin
        if (in_hs_s) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_ACC;
        end
      end
      ST_WAIT: begin
        if (wcnt_r == {WCNT_W{1'b0}}) begin
          state_s = last_pend_r ? ST_DONE : ST_ACC;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_s = ST_EMPTY;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_EMPTY;
    endcase
  end

  // State, accumulator, counters and merge-operand registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= ST_EMPTY;
      acc_sum_r     <= '0;
      acc_err_r     <= '0;
      cnt_r         <= '0;
      wcnt_r        <= '0;
      last_pend_r   <= 1'b0;
      mrg_sum_a_r   <= '0;
      mrg_error_a_r <= '0;
      mrg_sum_b_r   <= '0;
      mrg_error_b_r <= '0;
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_EMPTY: begin
          if (in_hs_s) begin
            acc_sum_r <= in_sum_i;
            acc_err_r <= in_error_i;
            cnt_r     <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        ST_ACC: begin
          // Operands stay frozen from here until the next issue
          if (in_hs_s) begin
            mrg_sum_a_r   <= acc_sum_r;
            mrg_error_a_r <= acc_err_r;
            mrg_sum_b_r   <= in_sum_i;
            mrg_error_b_r <= in_error_i;
            wcnt_r        <= WCNT_W'(MERGE_LAT);
            last_pend_r   <= in_last_i;
          end
        end
        ST_WAIT: begin
          if (wcnt_r != {WCNT_W{1'b0}}) begin
            wcnt_r <= wcnt_r - {{(WCNT_W-1){1'b0}}, 1'b1};
          end else begin
            acc_sum_r <= mrg_sum_i;
            acc_err_r <= mrg_error_i;
            cnt_r     <= cnt_inc_s;
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            acc_sum_r   <= '0;
            acc_err_r   <= '0;
            cnt_r       <= '0;
            last_pend_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fasttwosum_reduce_seq.sv
// Directed bench for fasttwosum_reduce_seq: frame table plus reset, backpressure and
// count-saturation sequences, against a behavioural E5M2 merge pipeline.
module tb_fasttwosum_reduce_seq;

  localparam int L = 3;

  typedef struct {
    int               n;
    logic [3:0][7:0]  s;
    logic [3:0][7:0]  e;
    logic [7:0]       exp_sum;
    logic [7:0]       exp_err;
    int               exp_cnt;
    int               bp;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_sum = 8'h00, in_err = 8'h00;
  logic        in_ready, out_valid;
  logic [7:0]  ma_s, ma_e, mb_s, mb_e, out_sum, out_err;
  logic [15:0] out_cnt;

  logic        s_in_valid = 1'b0, s_in_last = 1'b0, s_out_ready = 1'b0;
  logic [7:0]  s_in_sum = 8'h00;
  logic        s_in_ready, s_out_valid;
  logic [7:0]  s_ma_s, s_ma_e, s_mb_s, s_mb_e, s_out_sum, s_out_err;
  logic [2:0]  s_out_cnt;

  logic [7:0]  pipe0 [L];
  logic [7:0]  pipe1 [L];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  fasttwosum_reduce_seq #(.EXP_WIDTH_I(5), .MANT_WIDTH_I(2), .MERGE_LAT(L), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_sum_i(in_sum), .in_error_i(in_err), .in_last_i(in_last),
    .mrg_sum_a_o(ma_s), .mrg_error_a_o(ma_e), .mrg_sum_b_o(mb_s), .mrg_error_b_o(mb_e),
    .mrg_sum_i(pipe0[L-1]), .mrg_error_i(8'h00),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_sum_o(out_sum), .out_error_o(out_err), .out_count_o(out_cnt));

  fasttwosum_reduce_seq #(.EXP_WIDTH_I(5), .MANT_WIDTH_I(2), .MERGE_LAT(L), .CNT_WIDTH(3)) dut_sat (
    .clk_i(clk), .rst_i(rst), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
    .in_sum_i(s_in_sum), .in_error_i(8'h00), .in_last_i(s_in_last),
    .mrg_sum_a_o(s_ma_s), .mrg_error_a_o(s_ma_e), .mrg_sum_b_o(s_mb_s), .mrg_error_b_o(s_mb_e),
    .mrg_sum_i(pipe1[L-1]), .mrg_error_i(8'h00),
    .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
    .out_sum_o(s_out_sum), .out_error_o(s_out_err), .out_count_o(s_out_cnt));

  // Positive E5M2 values >= 1.0 (or zero) as multiples of 0.25
  function automatic int dec(input logic [7:0] b);
    int ex;
    ex = int'(b[6:2]);
    if (ex < 15) return 0;
    return (4 + int'(b[1:0])) << (ex - 15);
  endfunction

  function automatic logic [7:0] enc(input int q);
    int p;
    logic [4:0] ex;
    logic [1:0] m;
    if (q == 0) return 8'h00;
    p = 0;
    for (int k = 0; k < 31; k++) if ((q >> k) != 0) p = k;
    ex = 5'(15 + p - 2);
    m  = 2'((q >> (p - 2)) & 3);
    return {1'b0, ex, m};
  endfunction

  function automatic logic [7:0] fadd(input logic [7:0] a, input logic [7:0] b);
    return enc(dec(a) + dec(b));
  endfunction

  // Behavioural merge units: L-stage pipelines fed by each DUT's operand registers
  always @(posedge clk) begin
    pipe0[0] <= fadd(ma_s, mb_s);
    pipe1[0] <= fadd(s_ma_s, s_mb_s);
    for (int k = 1; k < L; k++) begin
      pipe0[k] <= pipe0[k-1];
      pipe1[k] <= pipe1[k-1];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] s, input logic [7:0] e, input logic l);
    int   g;
    logic took;
    g = 0;
    took = 1'b0;
    in_valid = 1'b1; in_sum = s; in_err = e; in_last = l;
    do begin
      took = in_ready;
      step();
      g++;
    end while (!took && g < 100);
    in_valid = 1'b0; in_last = 1'b0;
    check("accept", {31'd0, took}, 32'd1);
  endtask

  task automatic wait_valid(output int waited);
    waited = 0;
    while (!out_valid && waited < 200) begin
      step();
      waited++;
    end
    check("valid_seen", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic out_handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("empty_ready", {31'd0, in_ready}, 32'd1);
    check("empty_valid", {31'd0, out_valid}, 32'd0);
    check("empty_cnt", {16'd0, out_cnt}, 32'd0);
  endtask

  frame_t     tbl [6];
  logic [7:0] last_a, last_b, acc;
  int         first_cyc, w, g;

  initial begin
    tbl[0] = '{n:1, s:{8'h00, 8'h00, 8'h00, 8'h3C}, e:'0, exp_sum:8'h3C, exp_err:8'h00, exp_cnt:1, bp:0};
    tbl[1] = '{n:1, s:{8'h00, 8'h00, 8'h00, 8'h40}, e:{8'h00, 8'h00, 8'h00, 8'h05},
               exp_sum:8'h40, exp_err:8'h05, exp_cnt:1, bp:2};
    tbl[2] = '{n:2, s:{8'h00, 8'h00, 8'h40, 8'h3C}, e:'0, exp_sum:8'h42, exp_err:8'h00, exp_cnt:2, bp:0};
    tbl[3] = '{n:2, s:{8'h00, 8'h00, 8'h3C, 8'h40}, e:'0, exp_sum:8'h42, exp_err:8'h00, exp_cnt:2, bp:1};
    tbl[4] = '{n:4, s:{8'h3C, 8'h3C, 8'h3C, 8'h3C}, e:'0, exp_sum:8'h44, exp_err:8'h00, exp_cnt:4, bp:5};
    tbl[5] = '{n:3, s:{8'h00, 8'h40, 8'h40, 8'h40}, e:'0, exp_sum:8'h46, exp_err:8'h00, exp_cnt:3, bp:0};

    // Reset held two cycles with random input activity
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'($urandom); in_sum = 8'($urandom); in_err = 8'($urandom);
      in_last = 1'($urandom); out_ready = 1'($urandom);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out", {out_sum, out_err, out_cnt}, 32'd0);
    check("rst_mrg", {ma_s, ma_e, mb_s, mb_e}, 32'd0);
    last_a = 8'h00; last_b = 8'h00;

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < tbl[f].n; i++) begin
        push(tbl[f].s[i], tbl[f].e[i], i == tbl[f].n - 1);
        if (i == 0) first_cyc = cyc;
      end
      if (tbl[f].n >= 2) begin
        acc = tbl[f].s[0];
        for (int i = 1; i < tbl[f].n - 1; i++) acc = fadd(acc, tbl[f].s[i]);
        last_a = acc;
        last_b = tbl[f].s[tbl[f].n - 1];
      end
      check($sformatf("f%0d_mrg_a", f), {24'd0, ma_s}, {24'd0, last_a});
      check($sformatf("f%0d_mrg_b", f), {24'd0, mb_s}, {24'd0, last_b});
      wait_valid(w);
      // Valid shows in cycle (N-1)(L+2)+1 counting the first accept cycle as 0
      check($sformatf("f%0d_latency", f), 32'(cyc - first_cyc), 32'((tbl[f].n - 1) * (L + 2)));
      check($sformatf("f%0d_sum", f), {24'd0, out_sum}, {24'd0, tbl[f].exp_sum});
      check($sformatf("f%0d_err", f), {24'd0, out_err}, {24'd0, tbl[f].exp_err});
      check($sformatf("f%0d_cnt", f), {16'd0, out_cnt}, 32'(tbl[f].exp_cnt));
      check($sformatf("f%0d_busy", f), {31'd0, in_ready}, 32'd0);
      for (int k = 0; k < tbl[f].bp; k++) begin
        in_valid = 1'b1; in_sum = 8'hA5; in_err = 8'h5A; in_last = 1'b1;
        step();
        check($sformatf("f%0d_hold%0d", f, k), {out_valid, in_ready, 6'd0, out_sum, out_cnt},
              {1'b1, 1'b0, 6'd0, tbl[f].exp_sum, 16'(tbl[f].exp_cnt)});
      end
      in_valid = 1'b0; in_last = 1'b0;
      out_handshake();
    end

    // Reset during the second wait cycle drops the frame and its in-flight merge
    push(8'h40, 8'h00, 1'b0);
    push(8'h40, 8'h00, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_mrg", {ma_s, ma_e, mb_s, mb_e}, 32'd0);
    check("mid_rst_cnt", {16'd0, out_cnt}, 32'd0);
    push(8'h40, 8'h00, 1'b1);
    wait_valid(w);
    check("mid_rst_latency", 32'(w), 32'd0);
    check("mid_rst_sum", {24'd0, out_sum}, 32'h40);
    check("mid_rst_cnt1", {16'd0, out_cnt}, 32'd1);
    out_handshake();

    // Ten-element frame on the 3-bit counter instance saturates at 7
    for (int i = 0; i < 10; i++) begin
      s_in_valid = 1'b1; s_in_sum = 8'h3C; s_in_last = (i == 9);
      g = 0;
      while (!s_in_ready && g < 100) begin step(); g++; end
      step();
    end
    s_in_valid = 1'b0; s_in_last = 1'b0;
    g = 0;
    while (!s_out_valid && g < 200) begin step(); g++; end
    check("sat_valid", {31'd0, s_out_valid}, 32'd1);
    check("sat_cnt", {29'd0, s_out_cnt}, 32'd7);
    s_out_ready = 1'b1;
    step();
    s_out_ready = 1'b0;
    check("sat_empty", {30'd0, s_in_ready, s_out_valid}, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
